// File: rtl/display_pkg.sv
// display_pkg -- shared types and constants for the display-memory writers.
//
// Contents:
//   COUNT_W            width of the binary count fed to the digit writer
//   DIGIT_W            width of one decimal digit / glyph index
//   BLANK_GLYPH        glyph index drawn as an empty cell
//   MAX_COUNT          largest count that fits in three decimal digits
//   DEFAULT_COUNT_ADDR base word address of the three-digit count record
//   dw_state_t         digit_writer sequencer states
//   cv_phase_t         bin_to_bcd3 subtract phases
//   clamp_count()      saturate a count to MAX_COUNT
package display_pkg;

  localparam int unsigned     COUNT_W            = 10;
  localparam int unsigned     DIGIT_W            = 4;
  localparam logic [3:0]      BLANK_GLYPH        = 4'hA;
  localparam logic [9:0]      MAX_COUNT          = 10'd999;
  localparam logic [15:0]     DEFAULT_COUNT_ADDR = 16'h0100;

  typedef enum logic [2:0] {
    IDLE,
    SUB_HUN,
    SUB_TEN,
    WR_ONE,
    WR_TEN,
    WR_HUN,
    DONE
  } dw_state_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_HUN,
    CV_TEN
  } cv_phase_t;

  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

endpackage

// File: rtl/digit_writer_if.sv
// digit_writer_if -- request and memory-write bundle of the digit writer.
//
// Signals:
//   start      request conversion/write of value (sampled while idle)
//   value      binary count to display
//   busy       writer is not idle
//   done       one-cycle pulse after the third write commits
//   mem_we     display memory write request
//   mem_gnt    display memory write grant
//   mem_addr   display memory word address
//   mem_wdata  display memory write data (glyph index, zero-extended)
//
// Modports:
//   slave   the digit writer itself
//   master  the surrounding logic (count producer + memory arbiter)
interface digit_writer_if;
  import display_pkg::*;

  logic                start;
  logic [COUNT_W-1:0]  value;
  logic                busy;
  logic                done;
  logic                mem_we;
  logic                mem_gnt;
  logic [15:0]         mem_addr;
  logic [15:0]         mem_wdata;

  modport slave (
    input  start, value, mem_gnt,
    output busy, done, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output start, value, mem_gnt,
    input  busy, done, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/bin_to_bcd3.sv
// bin_to_bcd3 -- clamp a 10-bit count to 999 and split it into three
// decimal digits by repeated subtraction (hundreds first, then tens).
//
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   load_i       latch value_i and start converting (ignored unless idle)
//   value_i      binary count
//   busy_o       a conversion is in progress
//   hun_done_o   last hundreds-phase cycle (remainder already < 100)
//   valid_o      last tens-phase cycle; hun_o/ten_o/ones_o are final
//   hun_o        hundreds digit
//   ten_o        tens digit
//   ones_o       ones digit (low bits of the remainder)
//
// Digits hold their values after the conversion until the next load.
module bin_to_bcd3
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [COUNT_W-1:0] value_i,
  output logic               busy_o,
  output logic               hun_done_o,
  output logic               valid_o,
  output logic [DIGIT_W-1:0] hun_o,
  output logic [DIGIT_W-1:0] ten_o,
  output logic [DIGIT_W-1:0] ones_o
);

  cv_phase_t          phase_q, phase_d;
  logic [COUNT_W-1:0] rem_q,   rem_d;
  logic [DIGIT_W-1:0] hun_q,   hun_d;
  logic [DIGIT_W-1:0] ten_q,   ten_d;

  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    unique case (phase_q)
      CV_IDLE: begin
        if (load_i) begin
          rem_d   = clamp_count(value_i);
          hun_d   = '0;
          ten_d   = '0;
          phase_d = CV_HUN;
        end
      end
      CV_HUN: begin
        if (rem_q >= 10'd100) begin
          rem_d = rem_q - 10'd100;
          hun_d = hun_q + 4'd1;
        end else begin
          phase_d = CV_TEN;
        end
      end
      CV_TEN: begin
        if (rem_q >= 10'd10) begin
          rem_d = rem_q - 10'd10;
          ten_d = ten_q + 4'd1;
        end else begin
          phase_d = CV_IDLE;
        end
      end
      default: phase_d = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= CV_IDLE;
      rem_q   <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
    end
  end

  // Phase-exit flags are combinational so the sequencer can switch state on
  // the same edge the converter does.
  assign busy_o     = (phase_q != CV_IDLE);
  assign hun_done_o = (phase_q == CV_HUN) && (rem_q < 10'd100);
  assign valid_o    = (phase_q == CV_TEN) && (rem_q < 10'd10);
  assign hun_o      = hun_q;
  assign ten_o      = ten_q;
  // Once in the tens phase exits, rem_q < 10, so its low nibble is the ones digit.
  assign ones_o     = rem_q[DIGIT_W-1:0];

endmodule

// File: rtl/digit_writer.sv
// digit_writer -- convert a 10-bit count to three decimal glyph indices and
// write them to display memory: ones at COUNT_ADDR, tens at COUNT_ADDR+1,
// hundreds at COUNT_ADDR+2. A write commits on an edge with mem_we && mem_gnt;
// a low grant stretches the current write state.
//
// Ports:
//   clk     clock
//   reset   synchronous, active-low
//   bus     digit_writer_if.slave (start/value request, busy/done status,
//           mem_we/mem_gnt/mem_addr/mem_wdata memory write port)
//
// Parameters:
//   COUNT_ADDR  base word address of the three-digit record
//
// Build option:
//   DIGIT_WRITER_BLANK_EN  leading-zero blanking: hundreds 0 -> BLANK_GLYPH,
//                          tens 0 -> BLANK_GLYPH when hundreds is also 0.
//
// All outputs are registered; they are computed from the next state.
module digit_writer
  import display_pkg::*;
#(
  parameter logic [15:0] COUNT_ADDR = DEFAULT_COUNT_ADDR
) (
  input  logic           clk,
  input  logic           reset,
  digit_writer_if.slave  bus
);

  dw_state_t state_q, state_d;

  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        mem_we_q,    mem_we_d;
  logic [15:0] mem_addr_q,  mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic               cv_load;
  logic               cv_busy;
  logic               cv_hun_done;
  logic               cv_valid;
  logic [DIGIT_W-1:0] cv_hun, cv_ten, cv_ones;
  logic [DIGIT_W-1:0] hun_glyph, ten_glyph;

  assign cv_load = (state_q == IDLE) && bus.start && !cv_busy;

  bin_to_bcd3 u_cv (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cv_load),
    .value_i    (bus.value),
    .busy_o     (cv_busy),
    .hun_done_o (cv_hun_done),
    .valid_o    (cv_valid),
    .hun_o      (cv_hun),
    .ten_o      (cv_ten),
    .ones_o     (cv_ones)
  );

`ifdef DIGIT_WRITER_BLANK_EN
  assign hun_glyph = (cv_hun == '0) ? BLANK_GLYPH : cv_hun;
  assign ten_glyph = (cv_hun == '0 && cv_ten == '0) ? BLANK_GLYPH : cv_ten;
`else
  assign hun_glyph = cv_hun;
  assign ten_glyph = cv_ten;
`endif

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cv_load)     state_d = SUB_HUN;
      SUB_HUN: if (cv_hun_done) state_d = SUB_TEN;
      SUB_TEN: if (cv_valid)    state_d = WR_ONE;
      WR_ONE:  if (bus.mem_gnt) state_d = WR_TEN;
      WR_TEN:  if (bus.mem_gnt) state_d = WR_HUN;
      WR_HUN:  if (bus.mem_gnt) state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Registered outputs, derived from the state being entered.
  always_comb begin
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_d)
      WR_ONE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = COUNT_ADDR;
        mem_wdata_d = {{(16-DIGIT_W){1'b0}}, cv_ones};
      end
      WR_TEN: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = COUNT_ADDR + 16'd1;
        mem_wdata_d = {{(16-DIGIT_W){1'b0}}, ten_glyph};
      end
      WR_HUN: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = COUNT_ADDR + 16'd2;
        mem_wdata_d = {{(16-DIGIT_W){1'b0}}, hun_glyph};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_digit_writer.sv
// tb_digit_writer -- directed bench for digit_writer. Each run starts one
// conversion, then samples the bus 1 time unit after every rising edge,
// recording committed writes (address, data, cycle) and done pulses, with
// optional grant stalls, start spam, and a reset pulse at a chosen cycle.
module tb_digit_writer;

  localparam logic [15:0] BASE = 16'h0100;
`ifdef DIGIT_WRITER_BLANK_EN
  localparam logic [15:0] BLK = 16'h000A;
`else
  localparam logic [15:0] BLK = 16'h0000;
`endif

  logic clk;
  logic reset;

  digit_writer_if bus ();

  digit_writer #(.COUNT_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic [15:0] wr_addr [8];
  logic [15:0] wr_data [8];
  int          wr_cyc  [8];
  int          nwr;
  int          ndone;
  int          done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction. stall: grant-low cycles in WR_TEN; rst_cyc: cycle in
  // which reset is held low (0 = none); spam: keep start high while busy
  // and during DONE, with a different value on the bus.
  task automatic run(input logic [9:0] v, input int stall, input int rst_cyc, input bit spam);
    int          stall_left;
    logic [15:0] held;
    stall_left = stall;
    held       = '0;
    nwr        = 0;
    ndone      = 0;
    done_cyc   = 0;
    @(negedge clk);
    bus.value   = v;
    bus.start   = 1'b1;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;               // edge 0 sampled start
    bus.start = spam;
    if (spam) bus.value = 10'd5;
    for (int k = 1; k <= 40; k++) begin
      reset = (k == rst_cyc) ? 1'b0 : 1'b1;
      if (rst_cyc > 0 && k == rst_cyc + 1) begin
        chk("rst_busy", {31'b0, bus.busy},   32'd0);
        chk("rst_we",   {31'b0, bus.mem_we}, 32'd0);
        chk("rst_done", {31'b0, bus.done},   32'd0);
      end
      if (!reset) begin
        bus.mem_gnt = 1'b0;
      end else if (bus.mem_we && bus.mem_addr == BASE + 16'd1 && stall_left > 0) begin
        bus.mem_gnt = 1'b0;
        if (stall_left == stall) held = bus.mem_wdata;
        else begin
          chk("stall_addr", {16'b0, bus.mem_addr},  {16'b0, BASE + 16'd1});
          chk("stall_data", {16'b0, bus.mem_wdata}, {16'b0, held});
        end
        stall_left--;
      end else begin
        bus.mem_gnt = 1'b1;
      end
      if (bus.mem_we && bus.mem_gnt && nwr < 8) begin
        wr_addr[nwr] = bus.mem_addr;
        wr_data[nwr] = bus.mem_wdata;
        wr_cyc[nwr]  = k;
        nwr++;
      end
      if (bus.done) begin
        ndone++;
        done_cyc = k;
      end
      bus.start = spam && (ndone == 0 || k == done_cyc);
      @(posedge clk); #1;
    end
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mem_gnt = 1'b1;
  endtask

  task automatic check_rec(input string tag, input int n,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                           input int w0, input int w1, input int w2, input int dc);
    logic [15:0] d [3];
    int          w [3];
    d = '{d0, d1, d2};
    w = '{w0, w1, w2};
    chk({tag, "_nwr"}, nwr, n);
    for (int i = 0; i < n; i++) begin
      if (i < nwr) begin
        chk($sformatf("%s_addr%0d", tag, i), {16'b0, wr_addr[i]}, {16'b0, BASE + 16'(i)});
        chk($sformatf("%s_data%0d", tag, i), {16'b0, wr_data[i]}, {16'b0, d[i]});
        chk($sformatf("%s_cyc%0d",  tag, i), wr_cyc[i], w[i]);
      end
    end
    chk({tag, "_ndone"}, ndone, (dc > 0) ? 1 : 0);
    if (dc > 0) chk({tag, "_done_cyc"}, done_cyc, dc);
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.value   = '0;
    bus.mem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  {31'b0, bus.busy},      32'd0);
    chk("reset_done",  {31'b0, bus.done},      32'd0);
    chk("reset_we",    {31'b0, bus.mem_we},    32'd0);
    chk("reset_addr",  {16'b0, bus.mem_addr},  32'd0);
    chk("reset_wdata", {16'b0, bus.mem_wdata}, 32'd0);
    reset = 1'b1;

    // 256: h=2 t=5 -> writes 6,5,2 at cycles 10..12, done 13
    run(10'd256, 0, 0, 1'b0);
    check_rec("v256", 3, 16'd6, 16'd5, 16'd2, 10, 11, 12, 13);

    // 1023 clamps to 999
    run(10'd1023, 0, 0, 1'b0);
    check_rec("v1023", 3, 16'd9, 16'd9, 16'd9, 21, 22, 23, 24);

    run(10'd999, 0, 0, 1'b0);
    check_rec("v999", 3, 16'd9, 16'd9, 16'd9, 21, 22, 23, 24);

    run(10'd7, 0, 0, 1'b0);
    check_rec("v7", 3, 16'd7, BLK, BLK, 3, 4, 5, 6);

    run(10'd0, 0, 0, 1'b0);
    check_rec("v0", 3, 16'd0, BLK, BLK, 3, 4, 5, 6);

    // 40: tens nonzero, hundreds blanked when enabled
    run(10'd40, 0, 0, 1'b0);
    check_rec("v40", 3, 16'd0, 16'd4, BLK, 7, 8, 9, 10);

    // 305: tens 0 is not blanked because hundreds is nonzero
    run(10'd305, 0, 0, 1'b0);
    check_rec("v305", 3, 16'd5, 16'd0, 16'd3, 6, 7, 8, 9);

    // Grant low 3 cycles in WR_TEN
    run(10'd256, 3, 0, 1'b0);
    check_rec("stall", 3, 16'd6, 16'd5, 16'd2, 10, 14, 15, 16);

    // start held while busy and during DONE is ignored
    run(10'd256, 0, 0, 1'b1);
    check_rec("spam", 3, 16'd6, 16'd5, 16'd2, 10, 11, 12, 13);

    // Reset in SUB_TEN (cycle 6): nothing written
    run(10'd256, 0, 6, 1'b0);
    check_rec("rst_subten", 0, 16'd0, 16'd0, 16'd0, 0, 0, 0, 0);

    // Reset in WR_TEN (cycle 11): only the ones write survives
    run(10'd256, 0, 11, 1'b0);
    check_rec("rst_wrten", 1, 16'd6, 16'd0, 16'd0, 10, 0, 0, 0);

    // Writer usable again after a reset abort
    run(10'd123, 0, 0, 1'b0);
    check_rec("v123", 3, 16'd3, 16'd2, 16'd1, 6, 7, 8, 9);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/digit_writer.md
# digit_writer

Converts a 10-bit binary count into three decimal digits and writes them as glyph indices into display memory, where the VGA bit generator reads them back. Sits between the count-producing logic and the shared memory write port. Ones digit goes to COUNT_ADDR, tens to COUNT_ADDR+1, hundreds to COUNT_ADDR+2.

## Interface
- COUNT_ADDR, 16'h0100 — base word address of the three-digit record.
- clk  in  1  — clock.
- reset  in  1  — synchronous, active-low.
- start  in  1  — request conversion and write of `value`. Sampled only in IDLE.
- value  in  10  — binary count to display.
- busy  out  1  — high whenever state ≠ IDLE.
- done  out  1  — one-cycle pulse after the third write commits.
- mem_we  out  1  — write request to the display memory port.
- mem_gnt  in  1  — write granted. A write commits on a rising edge where mem_we && mem_gnt.
- mem_addr  out  16  — write address.
- mem_wdata  out  16  — write data: digit zero-extended to 16 bits.

## Operation
- States: IDLE, SUB_HUN, SUB_TEN, WR_ONE, WR_TEN, WR_HUN, DONE.
- IDLE: on start, latch rem = (value > 999) ? 999 : value. Clear hun/ten to 0. Go to SUB_HUN. start in any other state is ignored.
- SUB_HUN: each cycle, if rem ≥ 100 then rem -= 100 and hun += 1. Otherwise go to SUB_TEN.
- SUB_TEN: same rule with 10 and ten. When rem < 10, ones = rem[3:0] and go to WR_ONE.
- WR_ONE, WR_TEN, WR_HUN:
  - mem_we = 1. mem_addr = COUNT_ADDR, +1, +2 respectively. mem_wdata = {12'b0, digit}.
  - Hold all three until the mem_gnt edge, then advance.
- DONE: done = 1 for one cycle, then go to IDLE.
- Arithmetic: rem is 10 bits; hun, ten and ones are 4 bits each, always ≤ 9. Address adds are modulo 2^16, so COUNT_ADDR = 16'hFFFF wraps to 0 and 1.
- mem_we is 0 in all non-WR states. mem_addr and mem_wdata may hold their last values there.
- Reset while busy: on the next edge go to IDLE and drop mem_we. No further writes occur; a partially written record is left as-is.
- mem_gnt low for N cycles in a WR state stretches that state by N cycles. No timeout.

## Timing
- Reset values: busy 0, done 0, mem_we 0, mem_addr 0, mem_wdata 0. State IDLE.
- Cycle numbering: start is sampled at edge 0. SUB_HUN occupies cycles 1..h+1, SUB_TEN h+2..h+t+2, the writes h+t+3..h+t+5 (with mem_gnt held high), and DONE is cycle h+t+6.
- Latency with mem_gnt held high: done at cycle h+t+6. Value 0 → 6. Value 999 → 24.
- A new start is accepted earliest the cycle after DONE, i.e. back in IDLE.
- All outputs are registered.

## Configuration
- DIGIT_WRITER_BLANK_EN defined: leading-zero blanking.
  - Hundreds digit 0 is written as BLANK_GLYPH (4'hA).
  - Tens digit 0 is written as BLANK_GLYPH only when the hundreds digit is also 0.
  - Ones is never blanked.
- Undefined: digits are written unmodified, and 4'hA never appears on mem_wdata.

## Structure
- Shared package display_pkg:
  - state enum.
  - DIGIT_W = 4.
  - BLANK_GLYPH = 4'hA.
  - MAX_COUNT = 999.
  - default COUNT_ADDR.
- Sub-module bin_to_bcd3: the clamp-and-iterative-subtract datapath.
  - Interface: load, value, busy, hun/ten/ones, valid.
  - Top level keeps the write sequencer and the memory handshake.

## Test plan
- Value 256 with mem_gnt tied high → writes (0x0100, 6), (0x0101, 5), (0x0102, 2) on consecutive cycles; done at cycle 13.
- Value 1023 → clamped to 999; writes 9, 9, 9; done at cycle 24.
- Value 7 with DIGIT_WRITER_BLANK_EN → writes 7, 0xA, 0xA. Without the macro → writes 7, 0, 0.
- mem_gnt low for 3 cycles during WR_TEN → mem_addr 0x0101 and mem_wdata held stable throughout. Exactly one commit; done delayed by 3 cycles.
- start pulses while busy, and start asserted together with DONE → ignored. Only the first record is written.
- reset low in SUB_TEN, and again in WR_TEN → IDLE next cycle, mem_we 0, busy 0, no done pulse, no further writes.
